// File: rtl/count_8bit.sv
// Free-running up-counter with asynchronous active-high clear, wrapping modulo 2^WIDTH.
// RESETN is active-high despite its name; the port name is kept for drop-in compatibility.
module count_8bit #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned STEP        = 1
) (
  input  logic             RESETN,
  input  logic             CLK,
  output logic [WIDTH-1:0] COUNT_OUT
);

  // Both constants are reduced to WIDTH bits so the addition wraps naturally.
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      cnt <= RST_V;
    end else begin
      cnt <= cnt + STEP_V;
    end
  end

  assign COUNT_OUT = cnt;

endmodule

// File: tb/tb_count_8bit.sv
// Directed bench for count_8bit: default 8-bit instance plus a WIDTH=4/STEP=3/RESET_VALUE=2 instance.
module tb_count_8bit;

  logic       clk;
  logic       rst;
  logic       rst2;
  logic [7:0] cnt;
  logic [3:0] cnt2;

  int unsigned checks;
  int unsigned failures;

  count_8bit dut (
    .RESETN    (rst),
    .CLK       (clk),
    .COUNT_OUT (cnt)
  );

  count_8bit #(
    .WIDTH       (4),
    .RESET_VALUE (2),
    .STEP        (3)
  ) dut_p (
    .RESETN    (rst2),
    .CLK       (clk),
    .COUNT_OUT (cnt2)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rst2     = 1'b1;

    // Power-up window: reset held, two rising edges inside it.
    #10;
    chk("pwr_t10", cnt, 8'h00);
    chk("p_pwr_t10", {4'h0, cnt2}, 8'h02);
    @(posedge clk); #1;
    chk("pwr_edge1", cnt, 8'h00);
    @(posedge clk); #1;
    chk("pwr_edge2", cnt, 8'h00);
    chk("p_pwr_edge2", {4'h0, cnt2}, 8'h02);

    // Release at t=100, clear of any clock edge.
    #24;
    rst  = 1'b0;
    rst2 = 1'b0;

    // Count 1..5 with stability check late in each period; param instance 5,8,11,14,1.
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk("count", cnt, 8'(i));
      chk("p_count", {4'h0, cnt2}, 8'((2 + 3 * i) % 16));
      #47;
      chk("count_stable", cnt, 8'(i));
    end
    @(posedge clk); #1;
    chk("p_count6", {4'h0, cnt2}, 8'h04);
    @(posedge clk); #1;
    chk("p_count7", {4'h0, cnt2}, 8'h07);

    // 7 edges taken so far; 248 more reach 255.
    repeat (248) @(posedge clk);
    #1;
    chk("wrap_255", cnt, 8'hFF);
    @(posedge clk); #1;
    chk("wrap_0", cnt, 8'h00);
    @(posedge clk); #1;
    chk("wrap_1", cnt, 8'h01);

    // Advance to 0x5A, then assert reset 10 ns after the rising edge.
    repeat (89) @(posedge clk);
    #1;
    chk("reach_5a", cnt, 8'h5A);
    #9;
    rst = 1'b1;
    #1;
    chk("async_rst", cnt, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold", cnt, 8'h00);
    end
    #34;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release", cnt, 8'h01);

    // Advance to 0x10, then raise reset on the same edge.
    repeat (15) @(posedge clk);
    #1;
    chk("reach_10", cnt, 8'h10);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("coincident_rst", cnt, 8'h00);
    #20;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("coincident_release", cnt, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
